// File: rtl/nios2_mul_result_combine.sv
// ============================================================================
// Module   : nios2_mul_result_combine
// Purpose  : Combines registered 16x16 partial products into the low 32-bit
//            multiply result across the A and W pipeline stages.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nios2_mul_result_combine #(
  parameter int REGNUM_W = 5,
  parameter bit FAST_W   = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                M_en,
  input  logic                M_mul_valid,
  input  logic                M_kill,
  input  logic                A_kill,
  input  logic [31:0]         M_mul_cell_p1,
  input  logic [31:0]         M_mul_cell_p2,
  input  logic [31:0]         M_mul_cell_p3,
  input  logic [REGNUM_W-1:0] M_dst_regnum,
  output logic [31:0]         W_mul_result,
  output logic                W_mul_valid,
  output logic [REGNUM_W-1:0] W_dst_regnum,
  output logic                mul_busy
);

  logic [31:0]         r_a_p1;
  logic [15:0]         r_a_cross;
  logic                r_a_valid;
  logic [REGNUM_W-1:0] r_a_dst;

  logic [15:0]         w_m_cross;
  logic [31:0]         w_a_result;
  logic                w_a_valid_out;

  // Only the low halves of the cross terms land below product bit 32.
  assign w_m_cross     = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign w_a_result    = r_a_p1 + {r_a_cross, 16'h0000};
  assign w_a_valid_out = r_a_valid & ~A_kill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_p1    <= '0;
      r_a_cross <= '0;
      r_a_valid <= 1'b0;
      r_a_dst   <= '0;
    end else if (M_en) begin
      r_a_p1    <= M_mul_cell_p1;
      r_a_cross <= w_m_cross;
      r_a_valid <= M_mul_valid & ~M_kill;
      r_a_dst   <= M_dst_regnum;
    end else if (A_kill) begin
      // A flush during a stall drops the op but leaves its data in place.
      r_a_valid <= 1'b0;
    end
  end

  generate
    if (FAST_W) begin : g_fast_w
      assign W_mul_result = w_a_result;
      assign W_mul_valid  = w_a_valid_out;
      assign W_dst_regnum = r_a_dst;
      assign mul_busy     = r_a_valid;
    end else begin : g_reg_w
      logic [31:0]         r_w_result;
      logic                r_w_valid;
      logic [REGNUM_W-1:0] r_w_dst;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_w_result <= '0;
          r_w_valid  <= 1'b0;
          r_w_dst    <= '0;
        end else if (M_en) begin
          r_w_result <= w_a_result;
          r_w_valid  <= w_a_valid_out;
          r_w_dst    <= r_a_dst;
        end
      end

      assign W_mul_result = r_w_result;
      assign W_mul_valid  = r_w_valid;
      assign W_dst_regnum = r_w_dst;
      assign mul_busy     = r_a_valid | r_w_valid;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_nios2_mul_result_combine.sv
// ============================================================================
// Module   : tb_nios2_mul_result_combine
// Purpose  : Directed self-checking bench for nios2_mul_result_combine (FAST_W=0).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nios2_mul_result_combine;

  logic        clk;
  logic        reset_n;
  logic        M_en;
  logic        M_mul_valid;
  logic        M_kill;
  logic        A_kill;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic [4:0]  M_dst_regnum;
  logic [31:0] W_mul_result;
  logic        W_mul_valid;
  logic [4:0]  W_dst_regnum;
  logic        mul_busy;

  int checks = 0;
  int errors = 0;

  nios2_mul_result_combine #(.REGNUM_W(5), .FAST_W(1'b0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_en          (M_en),
    .M_mul_valid   (M_mul_valid),
    .M_kill        (M_kill),
    .A_kill        (A_kill),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .M_dst_regnum  (M_dst_regnum),
    .W_mul_result  (W_mul_result),
    .W_mul_valid   (W_mul_valid),
    .W_dst_regnum  (W_dst_regnum),
    .mul_busy      (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p1, input logic [31:0] p2,
                       input logic [31:0] p3, input logic [4:0] dst);
    M_mul_valid   = v;
    M_mul_cell_p1 = p1;
    M_mul_cell_p2 = p2;
    M_mul_cell_p3 = p3;
    M_dst_regnum  = dst;
  endtask

  task automatic chk_w(input string tag, input logic [31:0] res, input logic v,
                       input logic [4:0] dst, input logic busy);
    chk({tag, ".result"}, W_mul_result, res);
    chk({tag, ".valid"},  32'(W_mul_valid), 32'(v));
    chk({tag, ".dst"},    32'(W_dst_regnum), 32'(dst));
    chk({tag, ".busy"},   32'(mul_busy), 32'(busy));
  endtask

  initial begin
    reset_n = 1'b0;
    M_en    = 1'b1;
    M_kill  = 1'b0;
    A_kill  = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    #2;
    chk_w("reset", 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    chk_w("reset_hold", 32'h0, 1'b0, 5'd0, 1'b0);
    reset_n = 1'b1;
    tick();

    // Test 1: basic product, two-cycle latency
    drive(1'b1, 32'h0000000F, 32'h00000006, 32'h00000005, 5'd7);
    tick();
    chk_w("t1_a", 32'h0, 1'b0, 5'd0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk_w("t1_w", 32'h000B000F, 1'b1, 5'd7, 1'b1);
    tick();
    chk_w("t1_done", 32'h0, 1'b0, 5'd0, 1'b0);

    // Tests 2/3 back to back: -1*-1 wrap, then cross-term carry drop
    drive(1'b1, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd2);
    tick();
    drive(1'b1, 32'h00001234, 32'hABCD8000, 32'h12348000, 5'd3);
    tick();
    chk_w("t2_wrap", 32'h00000001, 1'b1, 5'd2, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk_w("t3_carry", 32'h00001234, 1'b1, 5'd3, 1'b1);
    tick();
    chk("t3_idle.valid", 32'(W_mul_valid), 32'd0);

    // Test 4: stall with A_kill, then back-to-back op after release
    drive(1'b1, 32'h00000100, 32'h00000002, 32'h00000003, 5'd3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    M_en = 1'b0;
    tick();
    chk_w("t4_stall1", 32'h0, 1'b0, 5'd0, 1'b1);
    A_kill = 1'b1;
    tick();
    A_kill = 1'b0;
    chk_w("t4_killed", 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    chk_w("t4_stall3", 32'h0, 1'b0, 5'd0, 1'b0);
    M_en = 1'b1;
    drive(1'b1, 32'h00000005, 32'h00000001, 32'h00000001, 5'd9);
    tick();
    chk_w("t4_dead", 32'h00050100, 1'b0, 5'd3, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk_w("t4_next", 32'h00020005, 1'b1, 5'd9, 1'b1);
    tick();

    // Test 5: M_kill, then an unkilled op immediately behind it
    drive(1'b1, 32'h00000077, 32'h0, 32'h0, 5'd4);
    M_kill = 1'b1;
    tick();
    M_kill = 1'b0;
    chk("t5_mkill.busy", 32'(mul_busy), 32'd0);
    drive(1'b1, 32'h00000010, 32'h00000001, 32'h00000000, 5'd5);
    tick();
    chk_w("t5_dead", 32'h00000077, 1'b0, 5'd4, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk_w("t5_next", 32'h00010010, 1'b1, 5'd5, 1'b1);
    tick();

    // A_kill with M_en=1: old op dropped, new op captured normally
    drive(1'b1, 32'h00000001, 32'h0, 32'h0, 5'd6);
    tick();
    drive(1'b1, 32'h00000002, 32'h0, 32'h0, 5'd8);
    A_kill = 1'b1;
    tick();
    A_kill = 1'b0;
    chk_w("akill_en", 32'h00000001, 1'b0, 5'd6, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    chk_w("akill_next", 32'h00000002, 1'b1, 5'd8, 1'b1);

    // Test 6: async reset mid-flight
    drive(1'b1, 32'h00000011, 32'h00000001, 32'h0, 5'd10);
    tick();
    drive(1'b1, 32'h00000022, 32'h00000002, 32'h0, 5'd11);
    tick();
    chk_w("t6_pre", 32'h00010011, 1'b1, 5'd10, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_w("t6_reset", 32'h0, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_w("t6_after1", 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    chk_w("t6_after2", 32'h0, 1'b0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
